// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_e;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] HEADER_DEF = 8'h55;

  function automatic logic len_ok(input logic [7:0] len_byte, input int max_len);
    return (len_byte != 8'd0) && (int'(len_byte) <= max_len);
  endfunction

endpackage

// File: rtl/rx_frame_parse_module_if.sv
// Byte-stream input, payload read port and frame status of the frame parser.
interface rx_frame_parse_module_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        RX_Data;
  logic              RX_Done_Sig;
  logic              Frame_Ack;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [7:0]        Rd_Data;
  logic              Frame_Valid;
  logic [7:0]        Frame_Len;
  logic              Err_Sig;
  logic [1:0]        Err_Code;
  logic              Busy;

  modport master (
    output RX_Data, RX_Done_Sig, Frame_Ack, Rd_Addr,
    input  Rd_Data, Frame_Valid, Frame_Len, Err_Sig, Err_Code, Busy
  );

  modport slave (
    input  RX_Data, RX_Done_Sig, Frame_Ack, Rd_Addr,
    output Rd_Data, Frame_Valid, Frame_Len, Err_Sig, Err_Code, Busy
  );
endinterface

// File: rtl/frame_buf_ram.sv
// Simple dual-port payload buffer: synchronous write, registered read.
// Only the read register is reset so the array still maps onto RAM primitives.
module frame_buf_ram #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 8'd0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_frame_parse_module.sv
// Assembles HEADER, LEN, payload, CSUM frames from the UART byte strobe into a
// payload buffer, flagging good frames or typed errors (bad len, csum, timeout).
module rx_frame_parse_module
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER       = HEADER_DEF,
  parameter int         MAX_LEN      = 16,
  parameter int         ADDR_W       = 4,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input logic                    CLOCK,
  input logic                    RST,
  rx_frame_parse_module_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d;
  logic [7:0]    flen_q, flen_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          we;
  logic [7:0]    rd_data;

  logic       rx_done;
  logic [7:0] rx_byte;

  assign rx_done = bus.RX_Done_Sig;
  assign rx_byte = bus.RX_Data;

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      len_q   <= 8'd0;
      sum_q   <= 8'd0;
      cnt_q   <= 8'd0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      flen_q  <= 8'd0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      flen_q  <= flen_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // A strobe on the timeout cycle takes the byte path, so the byte wins.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    valid_d = valid_q;
    flen_d  = flen_q;
    err_d   = 1'b0;
    code_d  = code_q;
    we      = 1'b0;

    if (bus.Frame_Ack) valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (rx_done && rx_byte == HEADER) begin
        state_d = ST_LEN;
        valid_d = 1'b0;
      end
    end else if (!rx_done) begin
      if (tmo_q == TO_LAST) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_LEN: begin
          if (len_ok(rx_byte, MAX_LEN)) begin
            len_d   = rx_byte;
            sum_d   = rx_byte;
            cnt_d   = 8'd0;
            state_d = ST_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          we    = 1'b1;
          sum_d = sum_q + rx_byte;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_byte == sum_q) begin
            valid_d = 1'b1;
            flen_d  = len_q;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  frame_buf_ram #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk   (CLOCK),
    .rst   (RST),
    .we    (we),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata (rx_byte),
    .raddr (bus.Rd_Addr),
    .rdata (rd_data)
  );

  assign bus.Rd_Data     = rd_data;
  assign bus.Frame_Valid = valid_q;
  assign bus.Frame_Len   = flen_q;
  assign bus.Err_Sig     = err_q;
  assign bus.Err_Code    = code_q;
  assign bus.Busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_frame_parse_module.sv
// Directed bench for the frame parser; timeout shortened to keep runs short.
module tb_rx_frame_parse_module;

  localparam int TB_TMO = 20;

  logic CLOCK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;

  always #5 CLOCK = ~CLOCK;

  rx_frame_parse_module_if #(.ADDR_W(4)) bus ();

  rx_frame_parse_module #(
    .MAX_LEN      (16),
    .ADDR_W       (4),
    .TIMEOUT_CLKS (TB_TMO)
  ) u_dut (
    .CLOCK (CLOCK),
    .RST   (RST),
    .bus   (bus)
  );

  always @(posedge CLOCK) begin
    #1;
    if (bus.Err_Sig === 1'b1) err_seen++;
  end

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send(input logic [7:0] b, input logic ack);
    bus.RX_Data     = b;
    bus.RX_Done_Sig = 1'b1;
    bus.Frame_Ack   = ack;
    @(negedge CLOCK);
    bus.RX_Done_Sig = 1'b0;
    bus.Frame_Ack   = 1'b0;
  endtask

  task automatic ack_frame();
    bus.Frame_Ack = 1'b1;
    @(negedge CLOCK);
    bus.Frame_Ack = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.RX_Data = 8'd0;
    bus.RX_Done_Sig = 1'b0;
    bus.Frame_Ack = 1'b0;
    bus.Rd_Addr = '0;
    #2;
    checks++;
    if ({bus.Busy, bus.Frame_Valid, bus.Err_Sig} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/valid/err %b want 000", {bus.Busy, bus.Frame_Valid, bus.Err_Sig});
    end
    checks++;
    if ({bus.Frame_Len, bus.Err_Code, bus.Rd_Data} !== 18'd0) begin
      errors++; $display("FAIL reset_values: got len %0h code %0d rd %0h want 0", bus.Frame_Len, bus.Err_Code, bus.Rd_Data);
    end
    @(negedge CLOCK);
    @(negedge CLOCK);
    RST = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic test_good_frame();
    logic [7:0] exp [3];
    int e0;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    e0 = err_seen;
    send(8'h55, 1'b0); send(8'h03, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    send(8'h69, 1'b0);
    checks++;
    if (bus.Frame_Valid !== 1'b1 || bus.Frame_Len !== 8'd3) begin
      errors++; $display("FAIL good_valid: got valid %b len %0d want 1 3", bus.Frame_Valid, bus.Frame_Len);
    end
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++; $display("FAIL good_busy: got %b want 0", bus.Busy);
    end
    for (int i = 0; i < 3; i++) begin
      bus.Rd_Addr = 4'(i);
      @(negedge CLOCK);
      checks++;
      if (bus.Rd_Data !== exp[i]) begin
        errors++; $display("FAIL good_read%0d: got %0h want %0h", i, bus.Rd_Data, exp[i]);
      end
    end
    checks++;
    if (err_seen !== e0) begin
      errors++; $display("FAIL good_no_err: got %0d pulses want 0", err_seen - e0);
    end
    ack_frame();
    checks++;
    if (bus.Frame_Valid !== 1'b0) begin
      errors++; $display("FAIL good_ack: got valid %b want 0", bus.Frame_Valid);
    end
  endtask

  task automatic test_bad_csum();
    int e0;
    e0 = err_seen;
    send(8'h55, 1'b0); send(8'h02, 1'b0); send(8'hAA, 1'b0); send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    checks++;
    if (bus.Err_Sig !== 1'b1 || bus.Err_Code !== 2'd2) begin
      errors++; $display("FAIL csum_err: got err %b code %0d want 1 2", bus.Err_Sig, bus.Err_Code);
    end
    checks++;
    if (bus.Frame_Valid !== 1'b0 || bus.Frame_Len !== 8'd3) begin
      errors++; $display("FAIL csum_state: got valid %b len %0d want 0 3", bus.Frame_Valid, bus.Frame_Len);
    end
    @(negedge CLOCK);
    checks++;
    if (bus.Err_Sig !== 1'b0 || bus.Err_Code !== 2'd2 || err_seen !== e0 + 1) begin
      errors++; $display("FAIL csum_pulse: got err %b code %0d pulses %0d want 0 2 1", bus.Err_Sig, bus.Err_Code, err_seen - e0);
    end
    send(8'h55, 1'b0); send(8'h01, 1'b0); send(8'h7F, 1'b0); send(8'h80, 1'b0);
    bus.Rd_Addr = 4'd0;
    checks++;
    if (bus.Frame_Valid !== 1'b1 || bus.Frame_Len !== 8'd1) begin
      errors++; $display("FAIL csum_recover: got valid %b len %0d want 1 1", bus.Frame_Valid, bus.Frame_Len);
    end
    @(negedge CLOCK);
    checks++;
    if (bus.Rd_Data !== 8'h7F) begin
      errors++; $display("FAIL csum_recover_read: got %0h want 7f", bus.Rd_Data);
    end
  endtask

  task automatic test_bad_len();
    send(8'h55, 1'b0); send(8'h00, 1'b0);
    checks++;
    if (bus.Err_Sig !== 1'b1 || bus.Err_Code !== 2'd1 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL len0: got err %b code %0d busy %b want 1 1 0", bus.Err_Sig, bus.Err_Code, bus.Busy);
    end
    checks++;
    if (bus.Frame_Valid !== 1'b0) begin
      errors++; $display("FAIL len_hdr_clear: got valid %b want 0", bus.Frame_Valid);
    end
    send(8'h55, 1'b0);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Err_Sig !== 1'b0) begin
      errors++; $display("FAIL len_no_dead: got busy %b err %b want 1 0", bus.Busy, bus.Err_Sig);
    end
    send(8'h11, 1'b0);
    checks++;
    if (bus.Err_Sig !== 1'b1 || bus.Err_Code !== 2'd1 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL len17: got err %b code %0d busy %b want 1 1 0", bus.Err_Sig, bus.Err_Code, bus.Busy);
    end
    @(negedge CLOCK);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    send(8'h55, 1'b0); send(8'h02, 1'b0); send(8'hA0, 1'b0);
    for (int i = 1; i < TB_TMO; i++) begin
      @(negedge CLOCK);
      if (bus.Err_Sig !== 1'b0 || bus.Busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL tmo_early: got %0d early err/idle cycles want 0", early);
    end
    @(negedge CLOCK);
    checks++;
    if (bus.Err_Sig !== 1'b1 || bus.Err_Code !== 2'd3 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL tmo_fire: got err %b code %0d busy %b want 1 3 0", bus.Err_Sig, bus.Err_Code, bus.Busy);
    end
    @(negedge CLOCK);
  endtask

  task automatic test_timeout_byte_wins();
    int e0;
    send(8'h55, 1'b0); send(8'h02, 1'b0); send(8'hA0, 1'b0);
    e0 = err_seen;
    repeat (TB_TMO - 1) @(negedge CLOCK);
    send(8'hB0, 1'b0);
    checks++;
    if (bus.Err_Sig !== 1'b0 || bus.Busy !== 1'b1 || err_seen !== e0) begin
      errors++; $display("FAIL tmo_byte_wins: got err %b busy %b pulses %0d want 0 1 0", bus.Err_Sig, bus.Busy, err_seen - e0);
    end
    send(8'h52, 1'b0);
    bus.Rd_Addr = 4'd1;
    checks++;
    if (bus.Frame_Valid !== 1'b1 || bus.Frame_Len !== 8'd2) begin
      errors++; $display("FAIL tmo_frame: got valid %b len %0d want 1 2", bus.Frame_Valid, bus.Frame_Len);
    end
    @(negedge CLOCK);
    checks++;
    if (bus.Rd_Data !== 8'hB0) begin
      errors++; $display("FAIL tmo_read: got %0h want b0", bus.Rd_Data);
    end
  endtask

  task automatic test_garbage_header();
    logic [7:0] pre [3];
    int e0;
    pre[0] = 8'h00; pre[1] = 8'hFF; pre[2] = 8'h12;
    e0 = err_seen;
    ack_frame();
    foreach (pre[i]) send(pre[i], 1'b0);
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++; $display("FAIL garbage_idle: got busy %b want 0", bus.Busy);
    end
    send(8'h55, 1'b0); send(8'h02, 1'b0); send(8'h55, 1'b0); send(8'h55, 1'b0);
    send(8'hAC, 1'b0);
    checks++;
    if (bus.Frame_Valid !== 1'b1 || bus.Frame_Len !== 8'd2 || err_seen !== e0) begin
      errors++; $display("FAIL garbage_frame: got valid %b len %0d pulses %0d want 1 2 0", bus.Frame_Valid, bus.Frame_Len, err_seen - e0);
    end
    for (int i = 0; i < 2; i++) begin
      bus.Rd_Addr = 4'(i);
      @(negedge CLOCK);
      checks++;
      if (bus.Rd_Data !== 8'h55) begin
        errors++; $display("FAIL garbage_read%0d: got %0h want 55", i, bus.Rd_Data);
      end
    end
  endtask

  task automatic test_ack_coincident();
    send(8'h55, 1'b0); send(8'h01, 1'b0); send(8'h7F, 1'b0);
    send(8'h80, 1'b1);
    checks++;
    if (bus.Frame_Valid !== 1'b1) begin
      errors++; $display("FAIL ack_coincident: got valid %b want 1", bus.Frame_Valid);
    end
    ack_frame();
    checks++;
    if (bus.Frame_Valid !== 1'b0) begin
      errors++; $display("FAIL ack_after: got valid %b want 0", bus.Frame_Valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.Rd_Addr = 4'd1;
    send(8'h55, 1'b0); send(8'h03, 1'b0); send(8'h01, 1'b0);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Rd_Data !== 8'h55) begin
      errors++; $display("FAIL mid_pre: got busy %b rd %0h want 1 55", bus.Busy, bus.Rd_Data);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({bus.Busy, bus.Frame_Valid, bus.Err_Sig} !== 3'b000 ||
        {bus.Frame_Len, bus.Err_Code, bus.Rd_Data} !== 18'd0) begin
      errors++; $display("FAIL mid_async_reset: got busy %b valid %b err %b len %0h code %0d rd %0h want all 0",
                         bus.Busy, bus.Frame_Valid, bus.Err_Sig, bus.Frame_Len, bus.Err_Code, bus.Rd_Data);
    end
    @(negedge CLOCK);
    RST = 1'b0;
    @(negedge CLOCK);
    bus.Rd_Addr = 4'd0;
    send(8'h55, 1'b0); send(8'h01, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);
    checks++;
    if (bus.Frame_Valid !== 1'b1 || bus.Frame_Len !== 8'd1) begin
      errors++; $display("FAIL mid_recover: got valid %b len %0d want 1 1", bus.Frame_Valid, bus.Frame_Len);
    end
    @(negedge CLOCK);
    checks++;
    if (bus.Rd_Data !== 8'h05) begin
      errors++; $display("FAIL mid_recover_read: got %0h want 05", bus.Rd_Data);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_timeout_byte_wins();
    test_garbage_header();
    test_ack_coincident();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
